// File: rtl/counter_capture_if.sv
// Output stream of the counter capture FIFO: head entry plus valid/ready handshake.
// Latency: none, pure wiring bundle.
// Backpressure: consumer holds OUT_READY low to keep the head entry stable.
interface counter_capture_if;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_DATA;
  logic [3:0]  OUT_TAG;

  // Capture block drives the head entry, consumer drives ready.
  modport master (output OUT_VALID, output OUT_DATA, output OUT_TAG, input OUT_READY);
  modport slave  (input OUT_VALID, input OUT_DATA, input OUT_TAG, output OUT_READY);
endinterface

// File: rtl/counter_capture.sv
// Captures Q/MODO on rising edges of RCO or any LOAD bit into a small FIFO.
// Latency: an event at edge n is visible at the FIFO head right after edge n.
// Backpressure: OUT_READY low stalls the head; pushes into a full FIFO are dropped and counted.
module counter_capture #(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic [31:0]           Q,
  input  logic                  RCO,
  input  logic [7:0]            LOAD,
  input  logic [1:0]            MODO,
  input  logic                  CLR,
  counter_capture_if.master     out_if,
  output logic [4:0]            LEVEL,
  output logic                  OVF,
  output logic [7:0]            DROP_CNT
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] dat;
    logic [3:0]  tag;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            rco_q;
  logic            load_q;

  logic            load_any;
  logic            rco_evt;
  logic            load_evt;
  logic            evt;
  logic            full;
  logic            not_empty;
  logic            push;
  logic            pop;
  logic            drop;

  // Edge detection, event qualification and FIFO accept/drop decisions.
  always_comb begin
    load_any  = |LOAD;
    rco_evt   = RCO & ~rco_q;
    load_evt  = load_any & ~load_q;
    evt       = ENABLE & (rco_evt | load_evt);
    not_empty = (LEVEL != 5'd0);
    full      = (LEVEL == 5'(DEPTH));
    pop       = not_empty & out_if.OUT_READY;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    push      = evt & (~full | pop);
    drop      = evt & full & ~pop;
  end

  // Edge-detect history runs every cycle, independent of ENABLE.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      rco_q  <= 1'b0;
      load_q <= 1'b0;
    end else begin
      rco_q  <= RCO;
      load_q <= load_any;
    end
  end

  // Storage array is not reset; the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{dat: Q, tag: {MODO, load_evt, rco_evt}};
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      LEVEL  <= 5'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   LEVEL <= LEVEL + 5'd1;
        2'b01:   LEVEL <= LEVEL - 5'd1;
        default: LEVEL <= LEVEL;
      endcase
    end
  end

  // Sticky overflow and saturating drop counter; a drop beats a same-cycle clear.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      OVF      <= 1'b0;
      DROP_CNT <= 8'd0;
    end else if (drop) begin
      OVF <= 1'b1;
      if (CLR) begin
        DROP_CNT <= 8'd1;
      end else if (DROP_CNT != 8'hFF) begin
        DROP_CNT <= DROP_CNT + 8'd1;
      end
    end else if (CLR) begin
      OVF      <= 1'b0;
      DROP_CNT <= 8'd0;
    end
  end

  assign out_if.OUT_VALID = not_empty;
  assign out_if.OUT_DATA  = not_empty ? mem[rd_ptr].dat : 32'd0;
  assign out_if.OUT_TAG   = not_empty ? mem[rd_ptr].tag : 4'd0;

endmodule

// File: tb/tb_counter_capture.sv
// Bench for counter_capture: directed scenarios plus a queue scoreboard checked every cycle.
// Latency: scoreboard entries are due at the head one edge after the event edge.
// Backpressure: bench drives OUT_READY to exercise stall, drain, full push+pop and drops.
module tb_counter_capture;

  localparam int DEPTH = 4;

  logic        clk;
  logic        RESET;
  logic        ENABLE;
  logic [31:0] Q;
  logic        RCO;
  logic [7:0]  LOAD;
  logic [1:0]  MODO;
  logic        CLR;
  logic [4:0]  LEVEL;
  logic        OVF;
  logic [7:0]  DROP_CNT;

  counter_capture_if out_if ();

  counter_capture #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .RESET    (RESET),
    .ENABLE   (ENABLE),
    .Q        (Q),
    .RCO      (RCO),
    .LOAD     (LOAD),
    .MODO     (MODO),
    .CLR      (CLR),
    .out_if   (out_if.master),
    .LEVEL    (LEVEL),
    .OVF      (OVF),
    .DROP_CNT (DROP_CNT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: expected FIFO contents and status, updated when stimulus is sampled.
  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  t;
  } exp_t;

  exp_t sb[$];
  bit   m_rco_q  = 1'b0;
  bit   m_load_q = 1'b0;
  bit   m_ovf    = 1'b0;
  int   m_drop   = 0;
  bit   m_pop, m_rev, m_lev, m_evt, m_full;

  // Inputs are stable at the falling edge, so the model predicts the next rising edge here.
  always @(negedge clk) begin
    if (!RESET) begin
      sb.delete();
      m_rco_q  = 1'b0;
      m_load_q = 1'b0;
      m_ovf    = 1'b0;
      m_drop   = 0;
    end else begin
      check("sb_level", LEVEL, sb.size());
      check("sb_valid", out_if.OUT_VALID, (sb.size() != 0));
      check("sb_ovf", OVF, m_ovf);
      check("sb_drop", DROP_CNT, m_drop);
      if (sb.size() != 0) begin
        check("sb_head_dat", out_if.OUT_DATA, sb[0].d);
        check("sb_head_tag", out_if.OUT_TAG, sb[0].t);
      end
      m_pop  = (sb.size() != 0) && out_if.OUT_READY;
      m_rev  = RCO && !m_rco_q;
      m_lev  = (|LOAD) && !m_load_q;
      m_evt  = ENABLE && (m_rev || m_lev);
      m_full = (sb.size() == DEPTH);
      if (m_pop) void'(sb.pop_front());
      if (m_evt && (!m_full || m_pop)) sb.push_back({Q, MODO, m_lev, m_rev});
      if (m_evt && m_full && !m_pop) begin
        m_ovf  = 1'b1;
        m_drop = CLR ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
      end else if (CLR) begin
        m_ovf  = 1'b0;
        m_drop = 0;
      end
      m_rco_q  = RCO;
      m_load_q = |LOAD;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One RCO pulse: rising edge on the first cycle, low again on the second.
  task automatic rco_event(input logic [31:0] qv);
    Q   = qv;
    RCO = 1'b1;
    step();
    RCO = 1'b0;
    step();
  endtask

  initial begin
    RESET  = 1'b0;
    ENABLE = 1'b0;
    Q      = 32'd0;
    RCO    = 1'b0;
    LOAD   = 8'd0;
    MODO   = 2'd0;
    CLR    = 1'b0;
    out_if.OUT_READY = 1'b0;

    #2;
    check("rst_valid", out_if.OUT_VALID, 1'b0);
    check("rst_level", LEVEL, 5'd0);
    check("rst_data", out_if.OUT_DATA, 32'd0);
    check("rst_tag", out_if.OUT_TAG, 4'd0);
    check("rst_ovf", OVF, 1'b0);
    check("rst_drop", DROP_CNT, 8'd0);

    repeat (2) step();
    RESET = 1'b1;
    step();

    // Single RCO event into an empty FIFO.
    ENABLE = 1'b1;
    Q      = 32'h0000_00FF;
    MODO   = 2'b00;
    RCO    = 1'b1;
    step();
    check("single_valid", out_if.OUT_VALID, 1'b1);
    check("single_data", out_if.OUT_DATA, 32'h0000_00FF);
    check("single_tag", out_if.OUT_TAG, 4'b0001);
    check("single_level", LEVEL, 5'd1);
    RCO = 1'b0;
    out_if.OUT_READY = 1'b1;
    step();
    out_if.OUT_READY = 1'b0;
    check("single_drained", LEVEL, 5'd0);

    // RCO and LOAD rise together: one entry, both tag bits.
    Q    = 32'h1234_5678;
    MODO = 2'b11;
    RCO  = 1'b1;
    LOAD = 8'h01;
    step();
    check("simul_tag", out_if.OUT_TAG, 4'b1111);
    check("simul_data", out_if.OUT_DATA, 32'h1234_5678);
    check("simul_level", LEVEL, 5'd1);
    RCO  = 1'b0;
    LOAD = 8'h00;
    out_if.OUT_READY = 1'b1;
    step();
    out_if.OUT_READY = 1'b0;

    // Six events against a stalled consumer: four stored, two dropped.
    for (int i = 0; i < 6; i++) begin
      Q    = 32'd100 + 32'(i);
      MODO = 2'(i);
      if (i % 2 == 1) RCO = 1'b1;
      else            LOAD = 8'h10;
      step();
      RCO  = 1'b0;
      LOAD = 8'h00;
      step();
    end
    check("ovf_level", LEVEL, 5'd4);
    check("ovf_flag", OVF, 1'b1);
    check("ovf_drop", DROP_CNT, 8'd2);
    out_if.OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_order", out_if.OUT_DATA, 32'd100 + 32'(i));
      step();
    end
    out_if.OUT_READY = 1'b0;
    check("drain_empty", LEVEL, 5'd0);
    check("drain_ready_ignored", out_if.OUT_VALID, 1'b0);

    // Clear drops sticky status only.
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    check("clr_ovf", OVF, 1'b0);
    check("clr_drop", DROP_CNT, 8'd0);

    // Full FIFO with a simultaneous push and pop.
    MODO = 2'b00;
    for (int i = 0; i < 4; i++) rco_event(32'd200 + 32'(i));
    check("full_level", LEVEL, 5'd4);
    Q   = 32'h300;
    RCO = 1'b1;
    out_if.OUT_READY = 1'b1;
    step();
    RCO = 1'b0;
    out_if.OUT_READY = 1'b0;
    check("pushpop_level", LEVEL, 5'd4);
    check("pushpop_ovf", OVF, 1'b0);
    check("pushpop_head", out_if.OUT_DATA, 32'd201);
    step();

    // Five drops, then a clear colliding with a drop.
    for (int i = 0; i < 5; i++) rco_event(32'd400 + 32'(i));
    check("drops_ovf", OVF, 1'b1);
    check("drops_cnt", DROP_CNT, 8'd5);
    Q   = 32'd500;
    RCO = 1'b1;
    CLR = 1'b1;
    step();
    RCO = 1'b0;
    CLR = 1'b0;
    check("clrdrop_ovf", OVF, 1'b1);
    check("clrdrop_cnt", DROP_CNT, 8'd1);
    step();
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    check("clr2_ovf", OVF, 1'b0);
    check("clr2_cnt", DROP_CNT, 8'd0);
    check("clr2_fifo_kept", LEVEL, 5'd4);
    check("clr2_head_kept", out_if.OUT_DATA, 32'd201);

    // One pop, then an RCO rise with capture disabled.
    out_if.OUT_READY = 1'b1;
    step();
    out_if.OUT_READY = 1'b0;
    check("pop_level", LEVEL, 5'd3);
    ENABLE = 1'b0;
    MODO   = 2'b10;
    Q      = 32'd600;
    RCO    = 1'b1;
    step();
    check("en_gate_level", LEVEL, 5'd3);

    // Asynchronous reset mid-cycle at LEVEL=3 with RCO held high across release.
    ENABLE = 1'b1;
    #2;
    RESET = 1'b0;
    #1;
    check("arst_valid", out_if.OUT_VALID, 1'b0);
    check("arst_level", LEVEL, 5'd0);
    check("arst_data", out_if.OUT_DATA, 32'd0);
    step();
    RESET = 1'b1;
    step();
    check("rel_level", LEVEL, 5'd1);
    check("rel_tag", out_if.OUT_TAG, 4'b1001);
    check("rel_data", out_if.OUT_DATA, 32'd600);
    RCO = 1'b0;
    out_if.OUT_READY = 1'b1;
    step();
    step();
    check("final_empty", LEVEL, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
